tb_cmd_dispatcher: RTL and testbench

- Testbench stage directly downstream of the file-driven command sequencer.
- Consumes the tokenised argument strings plus args_valid, decodes args[0] as a command, and executes it against the DUT-facing signal vectors.
- Pulses ack to request the next line.
- Tracks check and protocol errors, and flags end of test.

---
 rtl/tb_dispatch_pkg.sv | 63 ++++++
 rtl/tb_edge_detect.sv | 26 ++
 rtl/tb_cmd_dispatcher.sv | 187 ++++++++++++++++++
 tb/tb_tb_cmd_dispatcher.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_dispatch_pkg.sv
// Shared types and helpers for the command dispatcher.
// The dispatcher top honours the optional compile-time macro TB_DISPATCH_TIMEOUT_EN.
package tb_dispatch_pkg;

    typedef enum logic [2:0] {
        REQ,
        IDLE,
        DECODE,
        EXEC,
        DONE,
        FINISHED
    } state_e;

    typedef enum logic [2:0] {
        CMD_SET,
        CMD_WAIT,
        CMD_WTR,
        CMD_WTF,
        CMD_CHK,
        CMD_END,
        CMD_BAD
    } cmd_e;

    localparam int ERR_CNT_W = 16;

    localparam string OP_SET  = "SET";
    localparam string OP_WAIT = "WAIT";
    localparam string OP_WTR  = "WTR";
    localparam string OP_WTF  = "WTF";
    localparam string OP_CHK  = "CHK";
    localparam string OP_END  = "END_TEST";

    // Map an opcode token to a command; anything unrecognised (including "") is CMD_BAD.
    function automatic cmd_e decode_op(input string op);
        if (op == OP_SET)  return CMD_SET;
        if (op == OP_WAIT) return CMD_WAIT;
        if (op == OP_WTR)  return CMD_WTR;
        if (op == OP_WTF)  return CMD_WTF;
        if (op == OP_CHK)  return CMD_CHK;
        if (op == OP_END)  return CMD_END;
        return CMD_BAD;
    endfunction

    // Parse an unsigned decimal token; returns 1 when a number was found.
    function automatic logic parse_uint(input string s, output logic [31:0] v);
        int unsigned tmp;
        int          n;
        tmp = 0;
        n   = $sscanf(s, "%d", tmp);
        v   = tmp;
        return (n == 1);
    endfunction

    // Parse a decimal token and keep only its least significant bit.
    function automatic logic parse_lsb(input string s, output logic b);
        logic [31:0] tmp;
        logic        ok;
        ok = parse_uint(s, tmp);
        b  = tmp[0];
        return ok;
    endfunction

endpackage

// File: rtl/tb_edge_detect.sv
// Registers the observed DUT signals and reports per-bit rising/falling edges.
module tb_edge_detect #(
    parameter int SIG_NB = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SIG_NB-1:0] wait_i,
    output logic [SIG_NB-1:0] rise,
    output logic [SIG_NB-1:0] fall
);

    logic [SIG_NB-1:0] wait_q;

    // Previous-cycle copy of the observed signals.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_i;
        end
    end

    assign rise = wait_i & ~wait_q;
    assign fall = ~wait_i & wait_q;

endmodule

// File: rtl/tb_cmd_dispatcher.sv
// Command dispatcher: decodes tokenised command lines from the sequencer and
// drives/observes DUT signals, pulsing ack to request the next line.
// Optional macro TB_DISPATCH_TIMEOUT_EN adds a timeout to WTR/WTF.
module tb_cmd_dispatcher
    import tb_dispatch_pkg::*;
#(
    parameter int ARGS_NB        = 5,
    parameter int SIG_NB         = 8,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  string                args [ARGS_NB],
    input  logic                 args_valid,
    output logic                 ack,
    output logic [SIG_NB-1:0]    set_o,
    input  logic [SIG_NB-1:0]    wait_i,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 end_test
);

    localparam int IDX_W = (SIG_NB > 1) ? $clog2(SIG_NB) : 1;

    state_e           state;
    cmd_e             cmd_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt;
    string            args_q [ARGS_NB];

    logic [SIG_NB-1:0] rise;
    logic [SIG_NB-1:0] fall;

    cmd_e             op_d;
    cmd_e             cmd_d;
    logic             ok_i;
    logic             ok_v;
    logic             v_bit;
    logic [31:0]      num_i;
    logic             idx_ok;
    logic [IDX_W-1:0] idx_d;
    logic             chk_miss;
    logic             edge_hit;
    logic             timeout_hit;
    logic             proto_err;
    logic             op_err;

    // Error counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] c,
                                                     input logic a, input logic b);
        logic [ERR_CNT_W:0] s;
        s = {1'b0, c} + (ERR_CNT_W+1)'(a) + (ERR_CNT_W+1)'(b);
        return s[ERR_CNT_W] ? '1 : s[ERR_CNT_W-1:0];
    endfunction

    tb_edge_detect #(
        .SIG_NB (SIG_NB)
    ) u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .wait_i (wait_i),
        .rise   (rise),
        .fall   (fall)
    );

    // Capture the command line when accepted in IDLE; tokens are data, not reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && args_valid) begin
            for (int k = 0; k < ARGS_NB; k++) begin
                args_q[k] <= args[k];
            end
        end
    end

    // Decode the latched line; malformed operands collapse the command to CMD_BAD.
    always_comb begin
        num_i  = '0;
        v_bit  = 1'b0;
        op_d   = decode_op(args_q[0]);
        ok_i   = parse_uint(args_q[1], num_i);
        ok_v   = parse_lsb(args_q[2], v_bit);
        idx_ok = ok_i && (num_i < 32'(SIG_NB));
        idx_d  = num_i[IDX_W-1:0];
        cmd_d  = op_d;
        case (op_d)
            CMD_SET, CMD_CHK: if (!(idx_ok && ok_v)) cmd_d = CMD_BAD;
            CMD_WTR, CMD_WTF: if (!idx_ok) cmd_d = CMD_BAD;
            CMD_WAIT:         if (!ok_i) cmd_d = CMD_BAD;
            default:          ;
        endcase
        chk_miss = (cmd_d == CMD_CHK) && (wait_i[idx_d] != v_bit);
    end

    // Edge qualification and error sources for this cycle.
    always_comb begin
        edge_hit  = (cmd_q == CMD_WTR) ? rise[idx_q] : fall[idx_q];
        proto_err = args_valid && (state != IDLE) && (state != FINISHED);
        op_err    = ((state == DECODE) && ((cmd_d == CMD_BAD) || chk_miss)) || timeout_hit;
    end

`ifdef TB_DISPATCH_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt;

    assign timeout_hit = (state == EXEC) && ((cmd_q == CMD_WTR) || (cmd_q == CMD_WTF)) &&
                         !edge_hit && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Cycles spent in EXEC since the current command was decoded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == DECODE) begin
            tmo_cnt <= '0;
        end else if (state == EXEC) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Dispatcher state machine with registered ack/set_o/err_cnt/end_test.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= REQ;
            cmd_q    <= CMD_BAD;
            idx_q    <= '0;
            cnt      <= '0;
            ack      <= 1'b0;
            set_o    <= '0;
            err_cnt  <= '0;
            end_test <= 1'b0;
        end else begin
            ack     <= 1'b0;
            err_cnt <= sat_add(err_cnt, proto_err, op_err);
            case (state)
                REQ: begin
                    ack   <= 1'b1;
                    state <= IDLE;
                end
                IDLE: begin
                    if (args_valid) state <= DECODE;
                end
                DECODE: begin
                    cmd_q <= cmd_d;
                    idx_q <= idx_d;
                    state <= DONE;
                    case (cmd_d)
                        CMD_SET:  set_o[idx_d] <= v_bit;
                        CMD_WAIT: begin
                            cnt <= CNT_W'(num_i);
                            if (num_i != '0) state <= EXEC;
                        end
                        CMD_WTR, CMD_WTF: state <= EXEC;
                        CMD_CHK: begin
                            if (chk_miss)
                                $display("[DISPATCH] CHK sig[%0d]: expected %0b, observed %0b",
                                         idx_d, v_bit, wait_i[idx_d]);
                        end
                        CMD_END: begin
                            end_test <= 1'b1;
                            state    <= FINISHED;
                        end
                        default: ;
                    endcase
                end
                EXEC: begin
                    if (cmd_q == CMD_WAIT) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) state <= DONE;
                    end else if (edge_hit) begin
                        state <= DONE;
                    end else if (timeout_hit) begin
                        $display("[DISPATCH] timeout waiting on sig[%0d]", idx_q);
                        state <= DONE;
                    end
                end
                DONE: begin
                    ack   <= 1'b1;
                    state <= IDLE;
                end
                FINISHED: ;
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_tb_cmd_dispatcher.sv
// Directed bench for tb_cmd_dispatcher. Inputs change and outputs are sampled
// on the falling edge; the DUT acts on the rising edge.
`timescale 1ns/1ps
module tb_tb_cmd_dispatcher;

    localparam int ARGS_NB = 5;
    localparam int SIG_NB  = 8;
    localparam int CNT_W   = 32;
    localparam int TMO     = 20;

    logic              clk        = 1'b0;
    logic              rst_n      = 1'b0;
    logic              args_valid = 1'b0;
    logic              ack;
    logic              end_test;
    string             args [ARGS_NB];
    logic [SIG_NB-1:0] set_o;
    logic [SIG_NB-1:0] wait_i = '0;
    logic [15:0]       err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tb_cmd_dispatcher #(
        .ARGS_NB        (ARGS_NB),
        .SIG_NB         (SIG_NB),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .args       (args),
        .args_valid (args_valid),
        .ack        (ack),
        .set_o      (set_o),
        .wait_i     (wait_i),
        .err_cnt    (err_cnt),
        .end_test   (end_test)
    );

    // Present one command line for a single cycle (called right after a falling edge).
    task automatic send(input string a0, input string a1, input string a2);
        args[0]    = a0;
        args[1]    = a1;
        args[2]    = a2;
        args[3]    = "";
        args[4]    = "";
        args_valid = 1'b1;
        @(negedge clk);
        args_valid = 1'b0;
    endtask

    // Falling edges until ack is seen, or -1 if it never shows within max.
    task automatic cycles_to_ack(input int max, output int n);
        n = -1;
        for (int c = 1; c <= max; c++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int hi;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b, expected 0", ack); end
        n_tests++; if (set_o !== 8'h00) begin n_fail++; $display("FAIL reset_set_o: got %h, expected 00", set_o); end
        n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d, expected 0", err_cnt); end
        n_tests++; if (end_test !== 1'b0) begin n_fail++; $display("FAIL reset_end_test: got %b, expected 0", end_test); end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL req_ack: got %b, expected 1", ack); end
        hi = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack !== 1'b0) hi++;
        end
        n_tests++; if (hi != 0) begin n_fail++; $display("FAIL req_single_pulse: got %0d extra ack cycles, expected 0", hi); end
    endtask

    task automatic test_set();
        send("SET", "3", "1");
        @(negedge clk);
        n_tests++; if (set_o !== 8'h08) begin n_fail++; $display("FAIL set_value: got %h, expected 08", set_o); end
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL set_ack_early: got %b, expected 0", ack); end
        @(negedge clk);
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL set_ack: got %b, expected 1", ack); end
        @(negedge clk);
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL set_ack_width: got %b, expected 0", ack); end
        n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL set_err_cnt: got %0d, expected 0", err_cnt); end
    endtask

    task automatic test_wait();
        int n;
        send("WAIT", "5", "");
        cycles_to_ack(30, n);
        n_tests++; if (n != 7) begin n_fail++; $display("FAIL wait5_latency: got %0d, expected 7", n); end
        send("WAIT", "0", "");
        cycles_to_ack(30, n);
        n_tests++; if (n != 2) begin n_fail++; $display("FAIL wait0_latency: got %0d, expected 2", n); end
        @(negedge clk);
        n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wait_ack_width: got %b, expected 0", ack); end
    endtask

    task automatic test_errors();
        int n;
        wait_i[1] = 1'b0;
        send("CHK", "1", "1");
        cycles_to_ack(10, n);
        n_tests++; if (n != 2) begin n_fail++; $display("FAIL chk_latency: got %0d, expected 2", n); end
        n_tests++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL chk_miss_err: got %0d, expected 1", err_cnt); end
        send("CHK", "1", "0");
        cycles_to_ack(10, n);
        n_tests++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL chk_match_err: got %0d, expected 1", err_cnt); end
        send("FOO", "", "");
        cycles_to_ack(10, n);
        n_tests++; if (n != 2) begin n_fail++; $display("FAIL bad_op_latency: got %0d, expected 2", n); end
        n_tests++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL bad_op_err: got %0d, expected 2", err_cnt); end
        send("SET", "9", "1");
        cycles_to_ack(10, n);
        n_tests++; if (err_cnt !== 16'd3) begin n_fail++; $display("FAIL set_range_err: got %0d, expected 3", err_cnt); end
        n_tests++; if (set_o !== 8'h08) begin n_fail++; $display("FAIL set_range_set_o: got %h, expected 08", set_o); end
        send("", "", "");
        cycles_to_ack(10, n);
        n_tests++; if (err_cnt !== 16'd4) begin n_fail++; $display("FAIL empty_op_err: got %0d, expected 4", err_cnt); end
        send("SET", "a", "1");
        cycles_to_ack(10, n);
        n_tests++; if (err_cnt !== 16'd5) begin n_fail++; $display("FAIL parse_err: got %0d, expected 5", err_cnt); end
        n_tests++; if (set_o !== 8'h08) begin n_fail++; $display("FAIL parse_set_o: got %h, expected 08", set_o); end
    endtask

    task automatic test_edges();
        int n;
        int hi;
        wait_i[2] = 1'b1;
        repeat (3) @(negedge clk);
        send("WTR", "2", "");
        hi = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) wait_i[5] = 1'b1;
            @(negedge clk);
            if (ack !== 1'b0) hi++;
        end
        n_tests++; if (hi != 0) begin n_fail++; $display("FAIL wtr_early_ack: got %0d ack cycles, expected 0", hi); end
        wait_i[2] = 1'b0;
        @(negedge clk);
        wait_i[2] = 1'b1;
        cycles_to_ack(10, n);
        n_tests++; if (n != 2) begin n_fail++; $display("FAIL wtr_latency: got %0d, expected 2", n); end
        send("WTF", "2", "");
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack !== 1'b0) hi++;
        end
        n_tests++; if (hi != 0) begin n_fail++; $display("FAIL wtf_early_ack: got %0d ack cycles, expected 0", hi); end
        wait_i[2] = 1'b0;
        cycles_to_ack(10, n);
        n_tests++; if (n != 2) begin n_fail++; $display("FAIL wtf_latency: got %0d, expected 2", n); end
        n_tests++; if (err_cnt !== 16'd5) begin n_fail++; $display("FAIL edges_err: got %0d, expected 5", err_cnt); end
    endtask

    task automatic test_protocol();
        int n;
        send("WAIT", "10", "");
        repeat (3) @(negedge clk);
        send("SET", "0", "1");
        cycles_to_ack(30, n);
        n_tests++; if (n != 8) begin n_fail++; $display("FAIL proto_wait_latency: got %0d, expected 8", n); end
        n_tests++; if (err_cnt !== 16'd6) begin n_fail++; $display("FAIL proto_err: got %0d, expected 6", err_cnt); end
        n_tests++; if (set_o !== 8'h08) begin n_fail++; $display("FAIL proto_set_o: got %h, expected 08", set_o); end
    endtask

`ifdef TB_DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        wait_i[0] = 1'b0;
        send("WTF", "0", "");
        cycles_to_ack(60, n);
        n_tests++; if (n != 22) begin n_fail++; $display("FAIL timeout_latency: got %0d, expected 22", n); end
        n_tests++; if (err_cnt !== 16'd7) begin n_fail++; $display("FAIL timeout_err: got %0d, expected 7", err_cnt); end
    endtask
`endif

    task automatic test_reset_mid();
        int hi;
        send("WAIT", "100", "");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (set_o !== 8'h00) begin n_fail++; $display("FAIL midrst_set_o: got %h, expected 00", set_o); end
        n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_err: got %0d, expected 0", err_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (ack !== 1'b1) begin n_fail++; $display("FAIL midrst_req_ack: got %b, expected 1", ack); end
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack !== 1'b0) hi++;
        end
        n_tests++; if (hi != 0) begin n_fail++; $display("FAIL midrst_stale_ack: got %0d ack cycles, expected 0", hi); end
    endtask

    task automatic test_end();
        int n;
        int hi;
        send("FOO", "", "");
        cycles_to_ack(10, n);
        n_tests++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL end_pre_err: got %0d, expected 1", err_cnt); end
        send("END_TEST", "", "");
        @(negedge clk);
        n_tests++; if (end_test !== 1'b1) begin n_fail++; $display("FAIL end_flag: got %b, expected 1", end_test); end
        send("SET", "1", "1");
        hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack !== 1'b0) hi++;
        end
        n_tests++; if (hi != 0) begin n_fail++; $display("FAIL end_ack: got %0d ack cycles, expected 0", hi); end
        n_tests++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL end_ignored_err: got %0d, expected 1", err_cnt); end
        n_tests++; if (set_o !== 8'h00) begin n_fail++; $display("FAIL end_set_o: got %h, expected 00", set_o); end
        n_tests++; if (end_test !== 1'b1) begin n_fail++; $display("FAIL end_sticky: got %b, expected 1", end_test); end
    endtask

    initial begin
        for (int k = 0; k < ARGS_NB; k++) args[k] = "";
        @(negedge clk);
        test_reset();
        test_set();
        test_wait();
        test_errors();
        test_edges();
        test_protocol();
`ifdef TB_DISPATCH_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_end();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no completion, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
